// File: rtl/osc_startup_pkg.sv
// osc_startup_pkg: state encoding and default parameters shared by the oscillator startup sequencer
package osc_startup_pkg;
  typedef enum logic [2:0] {SETTLE, WAIT_LOCK, REL_FAB, REL_PER, RUN, FAULT} state_t;
  localparam int DEF_STARTUP_CYCLES = 1024;
  localparam int DEF_LOCK_FILTER    = 16;
  localparam int DEF_STAGE_GAP      = 256;
  localparam int DEF_HEARTBEAT_DIV  = 25_000_000;
  localparam int DEF_WDOG_CYCLES    = 1_000_000;
endpackage

// File: rtl/osc_sync2.sv
// osc_sync2: two-flop synchroniser, async-reset to 0
//   clk in  sampling clock
//   rst in  asynchronous active-high reset
//   d   in  asynchronous input
//   q   out synchronised output
module osc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/osc_startup_seq.sv
// osc_startup_seq: oscillator settle / CCC lock filter / staged reset release sequencer with heartbeat
//   CLK            in  fabric oscillator clock
//   RESET          in  asynchronous active-high reset
//   LOCK           in  CCC lock, asynchronous to CLK
//   FAB_RESET_N    out fabric reset, active-low, registered
//   PERIPH_RESET_N out peripheral reset, active-low, registered
//   READY          out high only in RUN
//   HEARTBEAT      out LED drive, toggles every HEARTBEAT_DIV cycles while FAB_RESET_N=1
//   FAULT          out lock-wait timeout flag
// Define OSC_STARTUP_WDOG_EN to enable the lock-wait watchdog; otherwise FAULT is tied 0.
module osc_startup_seq #(
  parameter int STARTUP_CYCLES = osc_startup_pkg::DEF_STARTUP_CYCLES,
  parameter int LOCK_FILTER    = osc_startup_pkg::DEF_LOCK_FILTER,
  parameter int STAGE_GAP      = osc_startup_pkg::DEF_STAGE_GAP,
  parameter int HEARTBEAT_DIV  = osc_startup_pkg::DEF_HEARTBEAT_DIV,
  parameter int WDOG_CYCLES    = osc_startup_pkg::DEF_WDOG_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic LOCK,
  output logic FAB_RESET_N,
  output logic PERIPH_RESET_N,
  output logic READY,
  output logic HEARTBEAT,
  output logic FAULT
);
  import osc_startup_pkg::state_t;
  import osc_startup_pkg::SETTLE;
  import osc_startup_pkg::WAIT_LOCK;
  import osc_startup_pkg::REL_FAB;
  import osc_startup_pkg::REL_PER;
  import osc_startup_pkg::RUN;
  localparam int CW = $clog2(STARTUP_CYCLES > STAGE_GAP ? STARTUP_CYCLES : STAGE_GAP);
  localparam int FW = $clog2(LOCK_FILTER);
  localparam int HW = $clog2(HEARTBEAT_DIV);
  if (STARTUP_CYCLES < 2 || LOCK_FILTER < 2 || STAGE_GAP < 2 || HEARTBEAT_DIV < 2 || WDOG_CYCLES < 2)
  begin : g_bad_param
    $error("osc_startup_seq: all cycle parameters must be >= 2");
  end
  state_t state, next_state;
  logic run_en, lock_sync, fab_d, per_d, hb_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [FW-1:0] filt, filt_d;
  logic [HW-1:0] hb_cnt, hb_cnt_d;
  // RESET asserts asynchronously but the FSM only starts counting two clean edges after release
  osc_sync2 u_rst_sync (.clk(CLK), .rst(RESET), .d(1'b1), .q(run_en));
  osc_sync2 u_lock_sync (.clk(CLK), .rst(RESET), .d(LOCK), .q(lock_sync));
`ifdef OSC_STARTUP_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wd;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) wd <= '0;
    else wd <= (state == WAIT_LOCK && next_state == WAIT_LOCK) ? wd + WW'(1) : '0;
  assign FAULT = state == osc_startup_pkg::FAULT;
`else
  assign FAULT = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= SETTLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (!run_en) next_state = SETTLE;
    else
      case (state)
        SETTLE:    if (cnt == CW'(STARTUP_CYCLES - 1)) next_state = WAIT_LOCK;
        WAIT_LOCK: if (lock_sync && filt == FW'(LOCK_FILTER - 1)) next_state = REL_FAB;
`ifdef OSC_STARTUP_WDOG_EN
                   else if (wd == WW'(WDOG_CYCLES - 1)) next_state = osc_startup_pkg::FAULT;
        osc_startup_pkg::FAULT: next_state = state;
`endif
        REL_FAB:   next_state = !lock_sync ? WAIT_LOCK : cnt == CW'(STAGE_GAP - 1) ? REL_PER : REL_FAB;
        REL_PER:   next_state = lock_sync ? RUN : WAIT_LOCK;
        RUN:       if (!lock_sync) next_state = WAIT_LOCK;
        default:   next_state = SETTLE;
      endcase
  end
  // One counter serves both SETTLE and REL_FAB; it clears on every state change
  always_comb begin
    cnt_d = (next_state == state && (state == SETTLE || state == REL_FAB) && run_en) ? cnt + CW'(1) : '0;
    filt_d = (state == WAIT_LOCK && next_state == WAIT_LOCK && lock_sync) ? filt + FW'(1) : '0;
  end
  // Outputs drop on the same edge the FSM leaves on lock loss; heartbeat counts only once FAB_RESET_N is high
  always_comb begin
    fab_d = lock_sync && (state == REL_FAB || state == REL_PER || state == RUN);
    per_d = next_state == RUN;
    hb_cnt_d = (fab_d && FAB_RESET_N && hb_cnt != HW'(HEARTBEAT_DIV - 1)) ? hb_cnt + HW'(1) : '0;
    hb_d = fab_d && (FAB_RESET_N && hb_cnt == HW'(HEARTBEAT_DIV - 1) ? !HEARTBEAT : HEARTBEAT);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      cnt <= '0;
      filt <= '0;
      hb_cnt <= '0;
      FAB_RESET_N <= 1'b0;
      PERIPH_RESET_N <= 1'b0;
      READY <= 1'b0;
      HEARTBEAT <= 1'b0;
    end else begin
      cnt <= cnt_d;
      filt <= filt_d;
      hb_cnt <= hb_cnt_d;
      FAB_RESET_N <= fab_d;
      PERIPH_RESET_N <= per_d;
      READY <= per_d;
      HEARTBEAT <= hb_d;
    end
endmodule
